dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel and performs a byte-lane-masked access to an internal word array after a programmable number of wait states.
- Returns read data and an error flag over a valid/ready response channel.
- Replaces the zero-latency combinational data memory so the core can be run against stalling memory.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// number of wait states between request accept and response valid.
// Byte-lane-masked stores, full-word loads, and an error flag for
// misaligned or out-of-range addresses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  waitCnt;

    logic        latWrite;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [3:0]  latWstrb;

    logic [31:0] rspRdataQ;
    logic        rspErrQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        opWrite;
    logic [31:0] opAddr;
    logic [31:0] opWdata;
    logic [3:0]  opWstrb;
    logic [29:0] opWord;
    logic [IDX_W-1:0] opIdx;
    logic        opErr;

    // Access operands: live request when committing on the accept edge
    // (zero wait states), otherwise the copy latched at accept.
    always_comb begin
        accept  = (state == IDLE) && req_valid;
        commit  = ((state == WAIT) && (waitCnt <= 4'd1)) ||
                  (accept && (WAIT_CYCLES == 0));
        opWrite = (state == WAIT) ? latWrite : req_write;
        opAddr  = (state == WAIT) ? latAddr  : req_addr;
        opWdata = (state == WAIT) ? latWdata : req_wdata;
        opWstrb = (state == WAIT) ? latWstrb : req_wstrb;
        opWord  = opAddr[31:2];
        opIdx   = opWord[IDX_W-1:0];
        opErr   = (opAddr[1:0] != 2'b00) || ({2'b00, opWord} >= 32'(DEPTH_WORDS));
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt <= 4'd1) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register, request latch, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            latWrite  <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            latWstrb  <= '0;
            rspRdataQ <= '0;
            rspErrQ   <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                latWrite <= req_write;
                latAddr  <= req_addr;
                latWdata <= req_wdata;
                latWstrb <= req_wstrb;
                waitCnt  <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (commit) begin
                rspErrQ   <= opErr;
                rspRdataQ <= (opErr || opWrite) ? '0 : mem[opIdx];
            end
        end
    end

    // Array write; gated by reset so an access pending at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && commit && opWrite && !opErr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (opWstrb[i]) begin
                    mem[opIdx][8*i +: 8] <= opWdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rspRdataQ;
    assign rsp_err   = rspErrQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states,
// one with zero wait states, sharing clock and reset.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAIT_A = 2;

    logic        clk;
    logic        rst;

    logic        reqValidA, reqReadyA, reqWriteA, rspValidA, rspReadyA, rspErrA;
    logic [31:0] reqAddrA, reqWdataA, rspRdataA;
    logic [3:0]  reqWstrbA;

    logic        reqValidB, reqReadyB, reqWriteB, rspValidB, rspReadyB, rspErrB;
    logic [31:0] reqAddrB, reqWdataB, rspRdataB;
    logic [3:0]  reqWstrbB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] expRd;
        logic        expErr;
    } vecT;

    vecT vecB[7];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_write(reqWriteA),
        .req_addr(reqAddrA), .req_wdata(reqWdataA), .req_wstrb(reqWstrbA),
        .rsp_valid(rspValidA), .rsp_ready(rspReadyA),
        .rsp_rdata(rspRdataA), .rsp_err(rspErrA)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_write(reqWriteB),
        .req_addr(reqAddrB), .req_wdata(reqWdataB), .req_wstrb(reqWstrbB),
        .rsp_valid(rspValidB), .rsp_ready(rspReadyB),
        .rsp_rdata(rspRdataB), .rsp_err(rspErrB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitRspA(output int lat);
        lat = 0;
        while (!rspValidA && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic txnA(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] expRd, input logic expErr);
        int lat;
        chk({tag, "/req_ready"}, 32'(reqReadyA), 32'd1);
        reqValidA = 1'b1;
        reqWriteA = wr;
        reqAddrA  = addr;
        reqWdataA = wdata;
        reqWstrbA = strb;
        tick;
        reqValidA = 1'b0;
        reqWriteA = ~wr;
        reqAddrA  = 32'hFFFF_FFF8;
        reqWdataA = 32'h5A5A_5A5A;
        reqWstrbA = 4'b1111;
        waitRspA(lat);
        chk({tag, "/latency"}, 32'(lat), 32'(WAIT_A));
        chk({tag, "/rdata"}, rspRdataA, expRd);
        chk({tag, "/err"}, 32'(rspErrA), 32'(expErr));
        rspReadyA = 1'b1;
        tick;
        rspReadyA = 1'b0;
        chk({tag, "/rsp_valid_drop"}, 32'(rspValidA), 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b0;
        reqValidA = 0; reqWriteA = 0; reqAddrA = '0; reqWdataA = '0; reqWstrbA = '0; rspReadyA = 0;
        reqValidB = 0; reqWriteB = 0; reqAddrB = '0; reqWdataB = '0; reqWstrbB = '0; rspReadyB = 0;
        tick;
        tick;
        chk("reset/req_ready", 32'(reqReadyA), 32'd1);
        chk("reset/rsp_valid", 32'(rspValidA), 32'd0);
        chk("reset/rdata", rspRdataA, 32'd0);
        chk("reset/err", 32'(rspErrA), 32'd0);
        chk("resetB/req_ready", 32'(reqReadyB), 32'd1);
        chk("resetB/rsp_valid", 32'(rspValidB), 32'd0);
        rst = 1'b1;
        tick;

        // store / load round trip
        txnA("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        txnA("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // byte lanes
        txnA("st20", 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        txnA("st20m", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        txnA("ld20", 1'b0, 32'h20, 32'h0, 4'b1111, 32'h11BB33DD, 1'b0);
        txnA("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        txnA("ld20z", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);

        // errors and range boundaries
        txnA("ld22", 1'b0, 32'h22, 32'h0, 4'b0000, 32'h0, 1'b1);
        txnA("st0", 1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, 1'b0);
        txnA("stLast", 1'b1, 32'(4 * (DEPTH - 1)), 32'h0A0B0C0D, 4'b1111, 32'h0, 1'b0);
        txnA("stOor", 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
        txnA("ld0", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0);
        txnA("ldLast", 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'b0000, 32'h0A0B0C0D, 1'b0);
        txnA("ldMis1", 1'b0, 32'h11, 32'h0, 4'b0000, 32'h0, 1'b1);

        // response backpressure with a second request held pending
        reqValidA = 1'b1; reqWriteA = 1'b0; reqAddrA = 32'h10; reqWstrbA = 4'b0000;
        tick;
        reqAddrA = 32'h20;
        waitRspA(lat);
        chk("bp/latency", 32'(lat), 32'(WAIT_A));
        for (int k = 0; k < 5; k++) begin
            chk("bp/rsp_valid", 32'(rspValidA), 32'd1);
            chk("bp/rdata", rspRdataA, 32'hDEADBEEF);
            chk("bp/err", 32'(rspErrA), 32'd0);
            chk("bp/req_ready", 32'(reqReadyA), 32'd0);
            tick;
        end
        rspReadyA = 1'b1;
        tick;
        rspReadyA = 1'b0;
        chk("bp/idle_rsp_valid", 32'(rspValidA), 32'd0);
        chk("bp/idle_req_ready", 32'(reqReadyA), 32'd1);
        chk("bp/rdata_held", rspRdataA, 32'hDEADBEEF);
        tick;
        chk("bp/second_accept", 32'(reqReadyA), 32'd0);
        reqValidA = 1'b0;
        waitRspA(lat);
        chk("bp2/latency", 32'(lat), 32'(WAIT_A));
        chk("bp2/rdata", rspRdataA, 32'h11BB33DD);
        rspReadyA = 1'b1;
        tick;
        rspReadyA = 1'b0;

        // reset while waiting: the store must not land
        txnA("st40", 1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        reqValidA = 1'b1; reqWriteA = 1'b1; reqAddrA = 32'h40; reqWdataA = 32'h12345678; reqWstrbA = 4'b1111;
        tick;
        reqValidA = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk("rstWait/rsp_valid", 32'(rspValidA), 32'd0);
        chk("rstWait/req_ready", 32'(reqReadyA), 32'd1);
        rst = 1'b1;
        txnA("ld40", 1'b0, 32'h40, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

        // reset while responding: the store has already landed
        reqValidA = 1'b1; reqWriteA = 1'b1; reqAddrA = 32'h44; reqWdataA = 32'h55667788; reqWstrbA = 4'b1111;
        tick;
        reqValidA = 1'b0;
        waitRspA(lat);
        chk("rstResp/latency", 32'(lat), 32'(WAIT_A));
        rst = 1'b0;
        tick;
        chk("rstResp/rsp_valid", 32'(rspValidA), 32'd0);
        chk("rstResp/err", 32'(rspErrA), 32'd0);
        rst = 1'b1;
        txnA("ld44", 1'b0, 32'h44, 32'h0, 4'b0000, 32'h55667788, 1'b0);

        // zero wait states, continuous request stream
        vecB[0] = '{1'b1, 32'h0, 32'hA0A0A0A0, 4'b1111, 32'h0, 1'b0};
        vecB[1] = '{1'b1, 32'h4, 32'hB1B1B1B1, 4'b1111, 32'h0, 1'b0};
        vecB[2] = '{1'b0, 32'h0, 32'h0, 4'b0000, 32'hA0A0A0A0, 1'b0};
        vecB[3] = '{1'b0, 32'h4, 32'h0, 4'b0000, 32'hB1B1B1B1, 1'b0};
        vecB[4] = '{1'b0, 32'h3, 32'h0, 4'b0000, 32'h0, 1'b1};
        vecB[5] = '{1'b1, 32'h4, 32'h00001234, 4'b0011, 32'h0, 1'b0};
        vecB[6] = '{1'b0, 32'h4, 32'h0, 4'b0000, 32'hB1B11234, 1'b0};
        rspReadyB = 1'b1;
        reqValidB = 1'b1;
        reqWriteB = vecB[0].wr; reqAddrB = vecB[0].addr; reqWdataB = vecB[0].wdata; reqWstrbB = vecB[0].strb;
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("b2b/rsp_valid", 32'(rspValidB), 32'd1);
            chk("b2b/req_ready_busy", 32'(reqReadyB), 32'd0);
            chk("b2b/rdata", rspRdataB, vecB[i].expRd);
            chk("b2b/err", 32'(rspErrB), 32'(vecB[i].expErr));
            if (i < 6) begin
                reqWriteB = vecB[i+1].wr; reqAddrB = vecB[i+1].addr;
                reqWdataB = vecB[i+1].wdata; reqWstrbB = vecB[i+1].strb;
            end else begin
                reqValidB = 1'b0;
            end
            tick;
            chk("b2b/rsp_valid_gap", 32'(rspValidB), 32'd0);
            chk("b2b/req_ready_idle", 32'(reqReadyB), 32'd1);
        end
        rspReadyB = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
